keccak_squeeze: RTL

//   Squeeze-side reader for the Keccak-f[1600] permutation: takes the permuted
//   25x64-bit state, streams its rate lanes out as 64-bit words over valid/ready,
//   and re-runs the permutation whenever the rate is exhausted and words remain.

---
 rtl/keccak_squeeze.sv | 118 +++++++++++
 1 files changed

// File: rtl/keccak_squeeze.sv
// Squeeze-side reader for Keccak-f[1600]: streams the rate lanes of the permuted
// state as 64-bit words and requests another permutation when the rate runs out.
module keccak_squeeze #(
  parameter int RATE_LANES = 21,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sq_start,
  input  logic [CNT_W-1:0]     sq_nwords,
  input  logic [24:0][63:0]    state_in,
  output logic                 perm_start,
  input  logic                 perm_done,
  output logic [63:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 sq_done,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int LANE_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATE_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_STREAM    = 2'd1,
    S_PERM_REQ  = 2'd2,
    S_PERM_WAIT = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [LANE_W-1:0]               lane_q, lane_d;
  logic [CNT_W-1:0]                rem_q, rem_d;
  logic [RATE_LANES-1:0][63:0]     buf_q, buf_d;
  logic                            sq_done_q, sq_done_d;
  logic                            cap_unused;

  // Capacity lanes are deliberately never read into the buffer.
  assign cap_unused = ^state_in[24:RATE_LANES];

  // Output handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; while valid is high and ready low, out_data and
  // out_last hold their values, and valid never drops without a transfer.
  assign out_valid  = (state_q == S_STREAM);
  assign out_data   = out_valid ? buf_q[lane_q] : 64'd0;
  assign out_last   = out_valid && (rem_q == CNT_W'(1));
  assign perm_start = (state_q == S_PERM_REQ);
  assign sq_done    = sq_done_q;
  assign busy       = (state_q != S_IDLE);
  assign dbg_state  = state_q;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    rem_d     = rem_q;
    buf_d     = buf_q;
    sq_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sq_start) begin
          if (sq_nwords != '0) begin
            for (int i = 0; i < RATE_LANES; i++) buf_d[i] = state_in[i];
            lane_d  = '0;
            rem_d   = sq_nwords;
            state_d = S_STREAM;
          end else begin
            sq_done_d = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          lane_d = lane_q + LANE_W'(1);
          if (rem_q == CNT_W'(1)) begin
            sq_done_d = 1'b1;
            lane_d    = '0;
            state_d   = S_IDLE;
          end else if (lane_q == LAST_LANE) begin
            // Rate exhausted with words still owed: squeeze another block.
            lane_d  = '0;
            state_d = S_PERM_REQ;
          end
        end
      end
      S_PERM_REQ: begin
        state_d = S_PERM_WAIT;
      end
      S_PERM_WAIT: begin
        if (perm_done) begin
          for (int i = 0; i < RATE_LANES; i++) buf_d[i] = state_in[i];
          lane_d  = '0;
          state_d = S_STREAM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      sq_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      rem_q     <= rem_d;
      buf_q     <= buf_d;
      sq_done_q <= sq_done_d;
    end
  end

endmodule
